// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode 7-segment display.
// Shows a hex value with per-digit decimal points and optional leading-zero
// blanking. A new value is only taken into use at a frame boundary, so a frame
// never mixes old and new digits. Each digit slot opens with an all-off guard
// interval so that one digit's segments never appear under another digit's anode.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_BITS = 17,
  parameter int GUARD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int FRM_W = VAL_W + NUM_DIGITS + 1;
  localparam logic [REFRESH_BITS-1:0] GUARD_LIMIT = REFRESH_BITS'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t                  state, state_next;
  logic [REFRESH_BITS-1:0] cnt, cnt_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic                    slot_end, wrap;

  // Frame words are packed as {value, dp_in, blank_lz}.
  logic [FRM_W-1:0]        pending, active, active_next;
  logic                    pending_valid;

  logic [VAL_W-1:0]        act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    act_blz;

  logic [3:0]              nibble;
  logic                    dp_bit;
  logic                    blank_sel;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The outputs are registered from the next-cycle view of the scan position
  // and frame contents, so an/seg/dp always line up with the live counter.
  assign slot_end    = (cnt == {REFRESH_BITS{1'b1}});
  assign wrap        = slot_end && (idx == LAST_IDX);
  assign cnt_next    = cnt + 1'b1;
  assign idx_next    = slot_end ? (wrap ? '0 : idx + 1'b1) : idx;
  assign active_next = (wrap && pending_valid) ? pending : active;

  assign act_value = active_next[FRM_W-1 -: VAL_W];
  assign act_dp    = active_next[NUM_DIGITS:1];
  assign act_blz   = active_next[0];

  // Slot counter and digit index advance together; the index moves on slot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

  // Pending capture on load and commit into the active frame at the frame boundary.
  // A load on the boundary edge survives into pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      active        <= '0;
    end else begin
      if (wrap && pending_valid) begin
        active <= pending;
      end
      if (load) begin
        pending       <= {value, dp_in, blank_lz};
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GUARD;
    else        state <= state_next;
  end

  // Next state: guard for the first GUARD_CYCLES counts of each slot, drive after.
  always_comb begin
    state_next = (cnt_next < GUARD_LIMIT) ? GUARD : DRIVE;
  end

  // Select the digit about to be shown and work out whether it is a blanked leading zero.
  always_comb begin
    logic lz;
    nibble    = 4'h0;
    dp_bit    = 1'b0;
    blank_sel = 1'b0;
    lz        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz = lz && (act_value[4*i +: 4] == 4'h0);
      if (idx_next == IDX_W'(i)) begin
        nibble = act_value[4*i +: 4];
        dp_bit = act_dp[i];
        if (i != 0) blank_sel = act_blz && lz;
      end
    end
  end

  // FSM outputs: everything dark in GUARD, selected anode plus decoded digit in DRIVE.
  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state_next == DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_next == IDX_W'(i)) an_next[i] = 1'b0;
      end
      seg_next = blank_sel ? 7'h7F : hex_to_seg(nibble);
      dp_next  = ~dp_bit;
    end
  end

  // Output register: an, seg and dp always update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with a 16-cycle slot and 2 guard cycles.
// A cycle model predicts every output cycle; its predictions are queued at each
// clock edge and compared against the DUT on the following falling edge.
module tb_seg7_scan_driver;

  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int check_count = 0;
  int error_count = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: scan position plus active and pending frame contents.
  logic [3:0]  m_cnt = '0;
  logic [1:0]  m_idx = '0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;
  logic        m_blz = 1'b0;
  logic [15:0] p_val = '0;
  logic [3:0]  p_dp  = '0;
  logic        p_blz = 1'b0;
  logic        p_vld = 1'b0;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_BITS (4),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one load strobe; caller is positioned on a falling edge.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic b);
    value    = v;
    dp_in    = d;
    blank_lz = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic exp_t model_out(input logic [3:0] c, input logic [1:0] ix,
                                     input logic [15:0] v, input logic [3:0] d,
                                     input logic b, input logic fs);
    exp_t       e;
    logic [15:0] sh;
    e.cnt = c;
    e.fs  = fs;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (c >= 4'(GUARD)) begin
      sh    = v >> (4 * ix);
      e.an  = ~(4'b0001 << ix);
      e.seg = (ix != 2'd0 && b && sh == 16'h0) ? 7'h7F : seg_table[sh[3:0]];
      e.dp  = ~d[ix];
    end
    return e;
  endfunction

  // Reference model: steps once per rising edge and queues the expected outputs.
  initial begin
    logic wrap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = '0; m_idx = '0;
        m_val = '0; m_dp = '0; m_blz = 1'b0;
        p_val = '0; p_dp = '0; p_blz = 1'b0; p_vld = 1'b0;
        sb.delete();
      end else begin
        wrap = (m_cnt == 4'hF) && (m_idx == 2'd3);
        if (wrap && p_vld) begin
          m_val = p_val; m_dp = p_dp; m_blz = p_blz;
          p_vld = 1'b0;
        end
        if (load) begin
          p_val = value; p_dp = dp_in; p_blz = blank_lz;
          p_vld = 1'b1;
        end
        if (m_cnt == 4'hF) m_idx = m_idx + 2'd1;
        m_cnt = m_cnt + 4'd1;
        sb.push_back(model_out(m_cnt, m_idx, m_val, m_dp, m_blz, wrap));
      end
    end
  end

  // Scoreboard consumer: compare the DUT with the oldest prediction on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("an", 16'(an), 16'(e.an));
        checkOutput("seg", 16'(seg), 16'(e.seg));
        checkOutput("dp", 16'(dp), 16'(e.dp));
        checkOutput("frame_start", 16'(frame_start), 16'(e.fs));
        checkOutput("an_onehot0", 16'($onehot0(~an)), 16'd1);
        if (e.cnt < 4'(GUARD)) checkOutput("guard_an", 16'(an), 16'hF);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard_n;
    rst_n    = 1'b0;
    value    = '0;
    dp_in    = '0;
    load     = 1'b0;
    blank_lz = 1'b0;

    // Reset state.
    runCycles(3);
    checkOutput("rst_an", 16'(an), 16'hF);
    checkOutput("rst_seg", 16'(seg), 16'h7F);
    checkOutput("rst_dp", 16'(dp), 16'h1);
    checkOutput("rst_fs", 16'(frame_start), 16'h0);
    rst_n = 1'b1;

    // Free-running scan with all-zero frame.
    $display("[TB] scan with no load");
    runCycles(130);

    // Mid-frame load of 12AF with dp on digit 2.
    $display("[TB] mid-frame load 12AF");
    runCycles(20);
    applyStimulus(16'h12AF, 4'b0100, 1'b0);
    runCycles(140);

    // Leading-zero blanking.
    $display("[TB] leading-zero blanking");
    applyStimulus(16'h0007, 4'b0000, 1'b1);
    runCycles(130);
    applyStimulus(16'h0000, 4'b1010, 1'b1);
    runCycles(130);
    applyStimulus(16'h0100, 4'b1111, 1'b1);
    runCycles(130);

    // Two loads in one frame: only the last should appear.
    $display("[TB] double load");
    guard_n = 0;
    while (!(m_cnt == 4'd1 && m_idx == 2'd0) && guard_n < 200) begin
      @(negedge clk);
      guard_n++;
    end
    if (guard_n >= 200) checkOutput("frame_wait", 16'd0, 16'd1);
    applyStimulus(16'h1111, 4'b0001, 1'b0);
    runCycles(5);
    applyStimulus(16'h2222, 4'b0010, 1'b0);
    runCycles(140);

    // Load on the commit edge: earlier pending commits now, the new one a frame later.
    $display("[TB] load on commit edge");
    runCycles(10);
    applyStimulus(16'hC0DE, 4'b1000, 1'b0);
    guard_n = 0;
    while (!(m_cnt == 4'hF && m_idx == 2'd3) && guard_n < 200) begin
      @(negedge clk);
      guard_n++;
    end
    if (guard_n >= 200) checkOutput("commit_wait", 16'd0, 16'd1);
    applyStimulus(16'h5A3B, 4'b0110, 1'b0);
    runCycles(140);

    // Decoder coverage across all sixteen digits.
    $display("[TB] decode sweep");
    applyStimulus(16'h3210, 4'b0001, 1'b0);
    runCycles(128);
    applyStimulus(16'h7654, 4'b0010, 1'b0);
    runCycles(128);
    applyStimulus(16'hBA98, 4'b0100, 1'b0);
    runCycles(128);
    applyStimulus(16'hFEDC, 4'b1000, 1'b0);
    runCycles(128);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'($urandom), 4'($urandom), 1'($urandom));
      runCycles(80);
    end

    // Reset in the middle of a DRIVE interval with a load still pending.
    $display("[TB] reset mid-drive");
    applyStimulus(16'h9999, 4'b1111, 1'b0);
    guard_n = 0;
    while (!(m_cnt == 4'd8) && guard_n < 200) begin
      @(negedge clk);
      guard_n++;
    end
    if (guard_n >= 200) checkOutput("drive_wait", 16'd0, 16'd1);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_drive", 16'($onehot(~an)), 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_an", 16'(an), 16'hF);
    checkOutput("midrst_seg", 16'(seg), 16'h7F);
    checkOutput("midrst_dp", 16'(dp), 16'h1);
    checkOutput("midrst_fs", 16'(frame_start), 16'h0);
    runCycles(2);
    rst_n = 1'b1;
    runCycles(140);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
